// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//   Bundles the two handshaked buses of the ID/EX pipeline register:
//     - decode -> stage : id_valid / id_ready plus the decoded payload
//     - stage -> ALU    : ex_valid / ex_ready plus ALU operands, control and
//                         sideband fields
//   Flush and the forwarding buses are not part of either handshake, so they
//   stay outside the interface as plain ports of the stage.
//
//   Modports
//     master : the environment around the stage (decode and execute). It drives
//              the ID payload and ex_ready, and observes id_ready and the EX bus.
//     slave  : the ID/EX stage itself.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    // decode -> stage
    logic               id_valid;
    logic               id_ready;
    logic [D_WIDTH-1:0] id_pc;
    logic [A_WIDTH-1:0] id_rs1;
    logic [A_WIDTH-1:0] id_rs2;
    logic [A_WIDTH-1:0] id_rd;
    logic [D_WIDTH-1:0] id_rs1_data;
    logic [D_WIDTH-1:0] id_rs2_data;
    logic [D_WIDTH-1:0] id_imm;
    logic               id_alusrc;
    logic [3:0]         id_aluctrl;
    logic               id_regwrite;

    // stage -> execute
    logic               ex_valid;
    logic               ex_ready;
    logic               alusrc;
    logic [3:0]         aluctrl;
    logic [D_WIDTH-1:0] aluop1;
    logic [D_WIDTH-1:0] regop2;
    logic [D_WIDTH-1:0] immop;
    logic [D_WIDTH-1:0] ex_pc;
    logic [A_WIDTH-1:0] ex_rd;
    logic               ex_regwrite;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm,
               id_alusrc, id_aluctrl, id_regwrite,
               ex_ready,
        input  id_ready,
               ex_valid, alusrc, aluctrl, aluop1, regop2, immop,
               ex_pc, ex_rd, ex_regwrite
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm,
               id_alusrc, id_aluctrl, id_regwrite,
               ex_ready,
        output id_ready,
               ex_valid, alusrc, aluctrl, aluop1, regop2, immop,
               ex_pc, ex_rd, ex_regwrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Single-entry ID/EX pipeline register sitting directly in front of the ALU.
//   It captures one decoded instruction, resolves EX/MEM and MEM/WB operand
//   forwarding on its outputs, blocks issue on a load-use hazard and presents
//   the result to execute under a valid/ready handshake. Supports back-pressure
//   (ex_ready low) and flush (taken branch/jump).
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   bus (slave)       ID handshake + payload in, EX handshake + ALU inputs out
//   flush             kill the held instruction and drop the incoming one
//   fwd1_*            EX/MEM result (newest): wen, rd, data, is_load
//   fwd2_*            MEM/WB result: wen, rd, data
//
// Timing
//   One cycle ID -> ALU. Back-to-back issue with no bubble when execute
//   consumes and decode offers in the same cycle.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_stage_if.slave       bus,
    input  logic               flush,
    input  logic               fwd1_wen,
    input  logic [A_WIDTH-1:0] fwd1_rd,
    input  logic [D_WIDTH-1:0] fwd1_data,
    input  logic               fwd1_is_load,
    input  logic               fwd2_wen,
    input  logic [A_WIDTH-1:0] fwd2_rd,
    input  logic [D_WIDTH-1:0] fwd2_data
);

    // Operand bypass for one source register. x0 always reads as zero; the
    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic logic [D_WIDTH-1:0] fwd_operand(
        input logic [A_WIDTH-1:0] rs,
        input logic [D_WIDTH-1:0] held,
        input logic               f1_wen,
        input logic [A_WIDTH-1:0] f1_rd,
        input logic [D_WIDTH-1:0] f1_data,
        input logic               f2_wen,
        input logic [A_WIDTH-1:0] f2_rd,
        input logic [D_WIDTH-1:0] f2_data
    );
        logic [D_WIDTH-1:0] res;
        if (rs == '0) begin
            res = '0;
        end else if (f1_wen && (f1_rd == rs)) begin
            res = f1_data;
        end else if (f2_wen && (f2_rd == rs)) begin
            res = f2_data;
        end else begin
            res = held;
        end
        return res;
    endfunction

    // A load in EX/MEM has no data yet; any held source that names its rd must
    // wait. rs2 is checked regardless of alusrc because stores read it.
    function automatic logic load_use(
        input logic               full,
        input logic               f1_wen,
        input logic               f1_is_load,
        input logic [A_WIDTH-1:0] f1_rd,
        input logic [A_WIDTH-1:0] rs1,
        input logic [A_WIDTH-1:0] rs2
    );
        return full && f1_wen && f1_is_load && (f1_rd != '0) &&
               ((f1_rd == rs1) || (f1_rd == rs2));
    endfunction

    // ------------------------------------------------------------------
    // Stage p1: held instruction (the ID/EX register)
    // ------------------------------------------------------------------
    logic               vld_p1;
    logic [D_WIDTH-1:0] pc_p1;
    logic [A_WIDTH-1:0] rs1_p1;
    logic [A_WIDTH-1:0] rs2_p1;
    logic [A_WIDTH-1:0] rd_p1;
    logic [D_WIDTH-1:0] rs1_data_p1;
    logic [D_WIDTH-1:0] rs2_data_p1;
    logic [D_WIDTH-1:0] imm_p1;
    logic               alusrc_p1;
    logic [3:0]         aluctrl_p1;
    logic               regwrite_p1;

    logic               hazard;
    logic               ex_valid_int;
    logic               fire;
    logic               id_ready_int;
    logic               capture;
    logic [D_WIDTH-1:0] op1_p1;
    logic [D_WIDTH-1:0] op2_p1;

    always_comb begin
        hazard       = load_use(vld_p1, fwd1_wen, fwd1_is_load, fwd1_rd,
                                rs1_p1, rs2_p1);
        ex_valid_int = vld_p1 && !hazard;
        fire         = ex_valid_int && bus.ex_ready;
        // Ready depends only on local state and ex_ready, never on id_valid.
        id_ready_int = !vld_p1 || fire;
        capture      = bus.id_valid && id_ready_int && !flush;

        op1_p1 = fwd_operand(rs1_p1, rs1_data_p1, fwd1_wen, fwd1_rd, fwd1_data,
                             fwd2_wen, fwd2_rd, fwd2_data);
        op2_p1 = fwd_operand(rs2_p1, rs2_data_p1, fwd1_wen, fwd1_rd, fwd1_data,
                             fwd2_wen, fwd2_rd, fwd2_data);
    end

    // Occupancy. Flush wins over everything, including a same-cycle fire or
    // capture, so the incoming instruction is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1 <= 1'b1;
        end else if (fire) begin
            vld_p1 <= 1'b0;
        end
    end

    // Held fields. While an instruction waits (stall or load-use), its source
    // data are re-latched from the bypass each cycle so that a producer which
    // retires from MEM/WB during the wait is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            alusrc_p1   <= 1'b0;
            aluctrl_p1  <= '0;
            regwrite_p1 <= 1'b0;
        end else if (capture) begin
            pc_p1       <= bus.id_pc;
            rs1_p1      <= bus.id_rs1;
            rs2_p1      <= bus.id_rs2;
            rd_p1       <= bus.id_rd;
            rs1_data_p1 <= bus.id_rs1_data;
            rs2_data_p1 <= bus.id_rs2_data;
            imm_p1      <= bus.id_imm;
            alusrc_p1   <= bus.id_alusrc;
            aluctrl_p1  <= bus.id_aluctrl;
            regwrite_p1 <= bus.id_regwrite;
        end else if (vld_p1 && !fire) begin
            rs1_data_p1 <= op1_p1;
            rs2_data_p1 <= op2_p1;
        end
    end

    // ------------------------------------------------------------------
    // Stage p1 -> execute: ALU inputs and sideband
    // ------------------------------------------------------------------
    assign bus.id_ready    = id_ready_int;
    assign bus.ex_valid    = ex_valid_int;
    assign bus.alusrc      = alusrc_p1;
    assign bus.aluctrl     = aluctrl_p1;
    assign bus.aluop1      = op1_p1;
    assign bus.regop2      = op2_p1;
    assign bus.immop       = imm_p1;
    assign bus.ex_pc       = pc_p1;
    assign bus.ex_rd       = rd_p1;
    assign bus.ex_regwrite = regwrite_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. A queue-based reference (at most one
//   instruction in flight) is stepped on every clock and checked against the
//   DUT on every falling edge; directed literal checks pin the reference.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          fwd1_wen;
    logic [AW-1:0] fwd1_rd;
    logic [DW-1:0] fwd1_data;
    logic          fwd1_is_load;
    logic          fwd2_wen;
    logic [AW-1:0] fwd2_rd;
    logic [DW-1:0] fwd2_data;

    int n_cmp;
    int n_fail;

    id_ex_stage_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

    id_ex_stage #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush        (flush),
        .fwd1_wen     (fwd1_wen),
        .fwd1_rd      (fwd1_rd),
        .fwd1_data    (fwd1_data),
        .fwd1_is_load (fwd1_is_load),
        .fwd2_wen     (fwd2_wen),
        .fwd2_rd      (fwd2_rd),
        .fwd2_data    (fwd2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] pc, d1, d2, imm;
        logic [AW-1:0] rs1, rs2, rd;
        logic          alusrc;
        logic [3:0]    aluctrl;
        logic          regwrite;
    } instr_t;

    instr_t slot[$];

    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] rs, input logic [DW-1:0] held);
        if (rs == 0) return 0;
        if (fwd1_wen && fwd1_rd == rs) return fwd1_data;
        if (fwd2_wen && fwd2_rd == rs) return fwd2_data;
        return held;
    endfunction

    function automatic logic m_stalled_by_load();
        if (slot.size() == 0) return 1'b0;
        return fwd1_wen && fwd1_is_load && fwd1_rd != 0 &&
               (fwd1_rd == slot[0].rs1 || fwd1_rd == slot[0].rs2);
    endfunction

    function automatic logic m_ex_valid();
        return slot.size() != 0 && !m_stalled_by_load();
    endfunction

    function automatic logic m_id_ready();
        return slot.size() == 0 || (m_ex_valid() && bus.ex_ready);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            slot.delete();
        end else begin
            logic   issued;
            logic   taken;
            instr_t inc;
            issued = m_ex_valid() && bus.ex_ready;
            taken  = bus.id_valid && m_id_ready() && !flush;
            inc.pc = bus.id_pc;         inc.d1 = bus.id_rs1_data;
            inc.d2 = bus.id_rs2_data;   inc.imm = bus.id_imm;
            inc.rs1 = bus.id_rs1;       inc.rs2 = bus.id_rs2;
            inc.rd = bus.id_rd;         inc.alusrc = bus.id_alusrc;
            inc.aluctrl = bus.id_aluctrl; inc.regwrite = bus.id_regwrite;
            if (flush) begin
                slot.delete();
            end else begin
                if (issued) begin
                    void'(slot.pop_front());
                end else if (slot.size() != 0) begin
                    slot[0].d1 = resolve(slot[0].rs1, slot[0].d1);
                    slot[0].d2 = resolve(slot[0].rs2, slot[0].d2);
                end
                if (taken) slot.push_back(inc);
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("m_ex_valid", bus.ex_valid, m_ex_valid());
            chk("m_id_ready", bus.id_ready, m_id_ready());
            if (slot.size() != 0) begin
                chk("m_aluop1",   bus.aluop1,      resolve(slot[0].rs1, slot[0].d1));
                chk("m_regop2",   bus.regop2,      resolve(slot[0].rs2, slot[0].d2));
                chk("m_immop",    bus.immop,       slot[0].imm);
                chk("m_alusrc",   bus.alusrc,      slot[0].alusrc);
                chk("m_aluctrl",  bus.aluctrl,     slot[0].aluctrl);
                chk("m_ex_pc",    bus.ex_pc,       slot[0].pc);
                chk("m_ex_rd",    bus.ex_rd,       slot[0].rd);
                chk("m_regwrite", bus.ex_regwrite, slot[0].regwrite);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clr_fwd();
        fwd1_wen = 0; fwd1_rd = 0; fwd1_data = 0; fwd1_is_load = 0;
        fwd2_wen = 0; fwd2_rd = 0; fwd2_data = 0;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
        bus.id_alusrc = 0; bus.id_aluctrl = 0; bus.id_regwrite = 0;
        bus.ex_ready = 1; flush = 0;
        clr_fwd();
    endtask

    task automatic offer(input logic [DW-1:0] pc, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic [DW-1:0] imm, input logic asrc, input logic [3:0] actl,
                         input logic rw);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_alusrc = asrc; bus.id_aluctrl = actl; bus.id_regwrite = rw;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_id_ready", bus.id_ready, 1);
        chk("rst_aluop1",   bus.aluop1,   0);
        chk("rst_regop2",   bus.regop2,   0);
        chk("rst_ex_pc",    bus.ex_pc,    0);
        rst_n = 1;

        // flow: back-to-back, operands 5,6,7 on consecutive cycles
        for (int i = 0; i < 3; i++) begin
            offer(32'h1000 + 4*i, 1, 2, 3, 5 + i, 0, 0, 0, 4'h2, 1);
            neg();
            if (i > 0) chk("flow_aluop1", bus.aluop1, 5 + i - 1);
            nxt();
        end
        bus.id_valid = 0;
        neg();
        chk("flow_aluop1_last", bus.aluop1, 7);
        chk("flow_valid_last", bus.ex_valid, 1);
        nxt();
        neg();
        chk("flow_drained", bus.ex_valid, 0);
        nxt();

        // stall: 3 cycles of back-pressure, next instruction must survive
        offer(32'h100, 2, 5, 6, 32'h11, 32'h12, 0, 0, 4'h3, 1);
        nxt();
        offer(32'h104, 2, 5, 6, 32'h22, 32'h12, 0, 0, 4'h3, 1);
        bus.ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("stall_valid",    bus.ex_valid, 1);
            chk("stall_id_ready", bus.id_ready, 0);
            chk("stall_aluop1",   bus.aluop1,   32'h11);
            chk("stall_pc",       bus.ex_pc,    32'h100);
            nxt();
        end
        bus.ex_ready = 1;
        neg();
        chk("stall_release_ready", bus.id_ready, 1);
        nxt();
        bus.id_valid = 0;
        neg();
        chk("stall_next_aluop1", bus.aluop1, 32'h22);
        chk("stall_next_pc",     bus.ex_pc,  32'h104);
        nxt();

        // forwarding priority and refresh during stall
        offer(32'h200, 3, 0, 7, 32'h33, 32'h77, 0, 0, 4'h1, 1);
        nxt();
        bus.id_valid = 0; bus.ex_ready = 0;
        fwd1_wen = 1; fwd1_rd = 3; fwd1_data = 32'hAA;
        fwd2_wen = 1; fwd2_rd = 3; fwd2_data = 32'hBB;
        neg();
        chk("fwd_prio_aluop1", bus.aluop1, 32'hAA);
        chk("fwd_x0_regop2",   bus.regop2, 0);
        #1 fwd1_wen = 0;
        #1 chk("fwd2_aluop1",  bus.aluop1, 32'hBB);
        nxt();
        fwd2_wen = 0;
        neg();
        chk("fwd_refresh_aluop1", bus.aluop1, 32'hBB);
        bus.ex_ready = 1;
        nxt();
        offer(32'h300, 0, 3, 8, 32'h99, 32'h66, 0, 0, 4'h4, 1);
        nxt();
        bus.id_valid = 0;
        fwd1_wen = 1; fwd1_rd = 0; fwd1_data = 32'hCC;
        fwd2_wen = 1; fwd2_rd = 3; fwd2_data = 32'hDD;
        neg();
        chk("fwd_rs0_aluop1", bus.aluop1, 0);
        chk("fwd2_regop2",    bus.regop2, 32'hDD);
        chk("fwd_rs0_valid",  bus.ex_valid, 1);
        nxt();
        clr_fwd();

        // load-use on rs2 (alusrc=1), resolved by MEM/WB one cycle later
        offer(32'h400, 1, 4, 9, 32'h10, 32'h44, 32'h7, 1, 4'h5, 0);
        nxt();
        bus.id_valid = 0;
        fwd1_wen = 1; fwd1_is_load = 1; fwd1_rd = 4; fwd1_data = 32'hDEAD;
        neg();
        chk("lu_valid",    bus.ex_valid, 0);
        chk("lu_id_ready", bus.id_ready, 0);
        nxt();
        fwd1_wen = 0; fwd1_is_load = 0;
        fwd2_wen = 1; fwd2_rd = 4; fwd2_data = 32'h55;
        neg();
        chk("lu_resolved_valid", bus.ex_valid, 1);
        chk("lu_regop2",         bus.regop2,   32'h55);
        chk("lu_immop",          bus.immop,    32'h7);
        chk("lu_alusrc",         bus.alusrc,   1);
        nxt();
        clr_fwd();
        // a load targeting x0 never stalls
        offer(32'h480, 0, 0, 1, 0, 0, 0, 0, 4'h0, 1);
        nxt();
        bus.id_valid = 0;
        fwd1_wen = 1; fwd1_is_load = 1; fwd1_rd = 0;
        neg();
        chk("lu_x0_valid", bus.ex_valid, 1);
        nxt();
        clr_fwd();

        // flush with a held instruction and a new one offered
        offer(32'h500, 1, 2, 3, 32'h50, 0, 0, 0, 4'h6, 1);
        bus.ex_ready = 0;
        nxt();
        offer(32'h504, 1, 2, 3, 32'h51, 0, 0, 0, 4'h6, 1);
        flush = 1;
        neg();
        chk("flush_cycle_valid", bus.ex_valid, 1);
        nxt();
        flush = 0; bus.id_valid = 0;
        neg();
        chk("flush_after_valid", bus.ex_valid, 0);
        chk("flush_after_ready", bus.id_ready, 1);
        nxt();
        neg();
        chk("flush_nothing_captured", bus.ex_valid, 0);
        bus.ex_ready = 1;
        nxt();

        // asynchronous reset in the middle of a transfer
        offer(32'h600, 1, 2, 3, 32'h61, 0, 0, 0, 4'h7, 1);
        nxt();
        offer(32'h604, 1, 2, 3, 32'h62, 0, 0, 0, 4'h7, 1);
        bus.ex_ready = 0;
        #2;
        chk("pre_rst_valid", bus.ex_valid, 1);
        rst_n = 0;
        #1;
        chk("async_rst_valid",  bus.ex_valid, 0);
        chk("async_rst_ready",  bus.id_ready, 1);
        chk("async_rst_aluop1", bus.aluop1,   0);
        idle();
        nxt();
        rst_n = 1;
        neg();
        chk("post_rst_valid", bus.ex_valid, 0);
        nxt();
        offer(32'h700, 1, 0, 2, 32'h77, 0, 0, 0, 4'h8, 1);
        nxt();
        bus.id_valid = 0;
        neg();
        chk("post_rst_aluop1", bus.aluop1, 32'h77);
        nxt();
        repeat (2) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
